// File: rtl/ts_tx_framer.sv
// rtl/ts_tx_framer.sv - transceiver TX framer: IDLE / SOF / payload / checksum / EOF word sequencing
//
// Purpose: wraps FRAME_WORDS payload words into a frame for a 16-bit transceiver
// TX port. Between frames at least IDLE_GAP IDLE words are sent. A payload slot
// with no word available is filled with an IDLE word and counted as an underrun.
//
// Ports:
//   clk_i             link transmit word clock
//   reset_n_i         synchronous reset, active-low
//   enable_i          framing enable, only looked at while idle
//   in_valid_i        payload word available
//   in_data_i         payload word
//   in_ready_o        payload word taken when in_valid_i && in_ready_o
//   tx_d_o            word to the transceiver TX data port
//   tx_k_o            per-byte K flags, bit 0 covers tx_d_o[7:0]
//   frame_count_o     completed frames (EOF sent), wraps
//   underrun_count_o  payload-slot underruns, saturates
//   seq_o             sequence number carried by the next SOF

module ts_tx_framer #(
  parameter int FRAME_WORDS = 6,
  parameter int IDLE_GAP    = 4
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        enable_i,
  input  logic        in_valid_i,
  input  logic [15:0] in_data_i,
  output logic        in_ready_o,
  output logic [15:0] tx_d_o,
  output logic [1:0]  tx_k_o,
  output logic [31:0] frame_count_o,
  output logic [15:0] underrun_count_o,
  output logic [7:0]  seq_o
);

  localparam logic [15:0] IDLE_WORD = 16'h50BC;
  localparam logic [15:0] EOF_WORD  = 16'hFEFD;
  localparam logic [7:0]  SOF_LOW   = 8'h3C;
  localparam logic [1:0]  K_CTRL    = 2'b01;
  localparam logic [1:0]  K_DATA    = 2'b00;
  localparam logic [7:0]  GAP_MAX   = 8'(IDLE_GAP);
  localparam logic [7:0]  WORD_LAST = 8'(FRAME_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SOF,
    S_PAYLOAD,
    S_CKSUM,
    S_EOF
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] tx_d_q, tx_d_d;
  logic [1:0]  tx_k_q, tx_k_d;
  logic [7:0]  gap_q, gap_d;
  logic [7:0]  word_cnt_q, word_cnt_d;
  logic [15:0] cksum_q, cksum_d;
  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] underrun_q, underrun_d;
  logic [7:0]  seq_q, seq_d;
  logic [7:0]  gap_inc;

  // Gap count including the IDLE word being sent this cycle. Deciding on this
  // value makes the EOF-to-SOF distance exactly IDLE_GAP IDLE words.
  assign gap_inc = (gap_q >= GAP_MAX) ? GAP_MAX : gap_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    tx_d_d      = IDLE_WORD;
    tx_k_d      = K_CTRL;
    gap_d       = gap_q;
    word_cnt_d  = word_cnt_q;
    cksum_d     = cksum_q;
    frame_cnt_d = frame_cnt_q;
    underrun_d  = underrun_q;
    seq_d       = seq_q;

    unique case (state_q)
      S_IDLE: begin
        gap_d = gap_inc;
        if (enable_i && in_valid_i && (gap_inc >= GAP_MAX)) begin
          state_d = S_SOF;
        end
      end

      S_SOF: begin
        tx_d_d     = {seq_q, SOF_LOW};
        word_cnt_d = 8'd0;
        cksum_d    = 16'd0;
        state_d    = S_PAYLOAD;
      end

      S_PAYLOAD: begin
        if (in_valid_i) begin
          tx_d_d     = in_data_i;
          tx_k_d     = K_DATA;
          cksum_d    = cksum_q + in_data_i;
          word_cnt_d = word_cnt_q + 8'd1;
          if (word_cnt_q == WORD_LAST) begin
            state_d = S_CKSUM;
          end
        end else if (underrun_q != 16'hFFFF) begin
          underrun_d = underrun_q + 16'd1;
        end
      end

      S_CKSUM: begin
        tx_d_d  = cksum_q;
        tx_k_d  = K_DATA;
        state_d = S_EOF;
      end

      S_EOF: begin
        tx_d_d      = EOF_WORD;
        frame_cnt_d = frame_cnt_q + 32'd1;
        seq_d       = seq_q + 8'd1;
        gap_d       = 8'd0;
        state_d     = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q     <= S_IDLE;
      tx_d_q      <= IDLE_WORD;
      tx_k_q      <= K_CTRL;
      gap_q       <= 8'd0;
      word_cnt_q  <= 8'd0;
      cksum_q     <= 16'd0;
      frame_cnt_q <= 32'd0;
      underrun_q  <= 16'd0;
      seq_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      tx_d_q      <= tx_d_d;
      tx_k_q      <= tx_k_d;
      gap_q       <= gap_d;
      word_cnt_q  <= word_cnt_d;
      cksum_q     <= cksum_d;
      frame_cnt_q <= frame_cnt_d;
      underrun_q  <= underrun_d;
      seq_q       <= seq_d;
    end
  end

  assign in_ready_o       = (state_q == S_PAYLOAD);
  assign tx_d_o           = tx_d_q;
  assign tx_k_o           = tx_k_q;
  assign frame_count_o    = frame_cnt_q;
  assign underrun_count_o = underrun_q;
  assign seq_o            = seq_q;

endmodule

// File: tb/tb_ts_tx_framer.sv
// tb/tb_ts_tx_framer.sv - self-checking bench for ts_tx_framer

module tb_ts_tx_framer;

  localparam int FW  = 6;
  localparam int GAP = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'd0;
  logic        in_ready;
  logic [15:0] tx_d;
  logic [1:0]  tx_k;
  logic [31:0] frame_count;
  logic [15:0] underrun_count;
  logic [7:0]  seq;

  int checks = 0;
  int errors = 0;

  logic [17:0] tx_q[$];
  logic [15:0] acc_q[$];
  logic [15:0] src_q[$];
  logic [15:0] cks_q[$];
  bit          cap_en = 1'b0;

  int p_frames, p_underruns, p_errs, p_first_gap, p_min_gap, p_max_gap, p_leftover, p_mode_end;

  ts_tx_framer #(.FRAME_WORDS(FW), .IDLE_GAP(GAP)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .enable_i(enable), .in_valid_i(in_valid),
    .in_data_i(in_data), .in_ready_o(in_ready), .tx_d_o(tx_d), .tx_k_o(tx_k),
    .frame_count_o(frame_count), .underrun_count_o(underrun_count), .seq_o(seq)
  );

  always #5 clk = ~clk;

  // Record the transmitted word stream and every accepted payload word.
  always @(negedge clk) begin
    if (cap_en && reset_n) begin
      tx_q.push_back({tx_k, tx_d});
      if (in_valid && in_ready) acc_q.push_back(in_data);
    end
  end

  // Reference model: walks the captured stream as frames and derives what it
  // must contain from the accepted words (order, checksum, sequence, gaps).
  function automatic void parse(input logic [7:0] start_seq);
    int mode, gap, n, ai;
    bit first;
    logic [15:0] sum, d;
    logic [1:0] k;
    logic [7:0] es;
    bit is_idle, is_sof, is_eof;
    p_frames = 0; p_underruns = 0; p_errs = 0; p_first_gap = -1;
    p_min_gap = 1000000; p_max_gap = 0;
    cks_q.delete();
    mode = 0; gap = 0; n = 0; ai = 0; first = 1'b1; sum = 16'd0; es = start_seq;
    foreach (tx_q[i]) begin
      k = tx_q[i][17:16];
      d = tx_q[i][15:0];
      is_idle = (k == 2'b01) && (d == 16'h50BC);
      is_sof  = (k == 2'b01) && (d[7:0] == 8'h3C);
      is_eof  = (k == 2'b01) && (d == 16'hFEFD);
      case (mode)
        0: begin
          if (is_idle) gap++;
          else if (is_sof) begin
            if (first) p_first_gap = gap;
            else begin
              if (gap < p_min_gap) p_min_gap = gap;
              if (gap > p_max_gap) p_max_gap = gap;
            end
            first = 1'b0;
            if (d[15:8] !== es) p_errs++;
            mode = 1; n = 0; sum = 16'd0;
          end else p_errs++;
        end
        1: begin
          if (is_idle) p_underruns++;
          else if (k == 2'b00) begin
            if (n < FW) begin
              if (ai >= acc_q.size()) p_errs++;
              else if (acc_q[ai] !== d) p_errs++;
              ai++;
              sum = sum + d;
              n++;
            end else begin
              cks_q.push_back(d);
              if (d !== sum) p_errs++;
              mode = 2;
            end
          end else p_errs++;
        end
        default: begin
          if (is_eof) begin
            p_frames++; es = es + 8'd1; gap = 0; mode = 0;
          end else p_errs++;
        end
      endcase
    end
    p_leftover = acc_q.size() - ai;
    p_mode_end = mode;
  endfunction

  task automatic do_reset();
    cap_en = 1'b0;
    reset_n = 1'b0;
    enable = 1'b0;
    in_valid = 1'b0;
    src_q.delete();
    repeat (2) begin @(posedge clk); #1; end
    tx_q.delete();
    acc_q.delete();
    reset_n = 1'b1;
    cap_en = 1'b1;
  endtask

  task automatic drive(input int ncycles, input int valid_pct, input int hold_after,
                       input int hold_len, input int drop_en_after);
    int acc = 0;
    int hold = 0;
    for (int c = 0; c < ncycles; c++) begin
      if (src_q.size() > 0 && hold == 0 && $urandom_range(99) < valid_pct) begin
        in_valid = 1'b1; in_data = src_q[0];
      end else begin
        in_valid = 1'b0; in_data = 16'($urandom);
      end
      @(negedge clk);
      if (in_valid && in_ready) begin
        void'(src_q.pop_front());
        acc++;
        if (acc == hold_after) hold = hold_len;
        if (acc == drop_en_after) enable = 1'b0;
      end else if (hold > 0) hold--;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (tx_d !== 16'h50BC) begin errors++; $display("FAIL reset_tx_d: got %h expected 50bc", tx_d); end
    checks++; if (tx_k !== 2'b01) begin errors++; $display("FAIL reset_tx_k: got %b expected 01", tx_k); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if (seq !== 8'd0) begin errors++; $display("FAIL reset_seq: got %h expected 00", seq); end
    checks++; if (frame_count !== 32'd0) begin errors++; $display("FAIL reset_frame_count: got %0d expected 0", frame_count); end
    checks++; if (underrun_count !== 16'd0) begin errors++; $display("FAIL reset_underrun: got %0d expected 0", underrun_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_nominal();
    logic [17:0] exp_w[10];
    int sof_idx = -1;
    do_reset();
    enable = 1'b1;
    for (int i = 1; i <= FW; i++) src_q.push_back(16'(i));
    drive(40, 100, -1, 0, -1);
    exp_w[0] = {2'b01, 16'h003C};
    for (int i = 1; i <= FW; i++) exp_w[i] = {2'b00, 16'(i)};
    exp_w[7] = {2'b00, 16'h0015};
    exp_w[8] = {2'b01, 16'hFEFD};
    exp_w[9] = {2'b01, 16'h50BC};
    foreach (tx_q[i]) if (sof_idx < 0 && tx_q[i] != {2'b01, 16'h50BC}) sof_idx = i;
    checks++;
    if (sof_idx < 0 || sof_idx + 10 > tx_q.size()) begin
      errors++; $display("FAIL nominal_frame_found: got index %0d expected a full frame", sof_idx);
    end else begin
      for (int j = 0; j < 10; j++) begin
        checks++;
        if (tx_q[sof_idx + j] !== exp_w[j]) begin
          errors++; $display("FAIL nominal_word%0d: got %h expected %h", j, tx_q[sof_idx + j], exp_w[j]);
        end
      end
    end
    parse(8'd0);
    checks++; if (p_first_gap < GAP) begin errors++; $display("FAIL nominal_first_gap: got %0d expected >= %0d", p_first_gap, GAP); end
    checks++; if (frame_count !== 32'd1) begin errors++; $display("FAIL nominal_frame_count: got %0d expected 1", frame_count); end
    checks++; if (seq !== 8'd1) begin errors++; $display("FAIL nominal_seq: got %0d expected 1", seq); end
  endtask

  task automatic test_underrun();
    logic [15:0] exp_sum = 16'd0;
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < FW; i++) begin
      src_q.push_back(16'($urandom));
      exp_sum = exp_sum + src_q[i];
    end
    drive(60, 100, 2, 3, -1);
    parse(8'd0);
    checks++; if (p_underruns != 3) begin errors++; $display("FAIL underrun_idle_words: got %0d expected 3", p_underruns); end
    checks++; if (underrun_count !== 16'd3) begin errors++; $display("FAIL underrun_count: got %0d expected 3", underrun_count); end
    checks++;
    if (cks_q.size() != 1 || cks_q[0] !== exp_sum) begin
      errors++; $display("FAIL underrun_cksum: got %0d words first %h expected %h", cks_q.size(), (cks_q.size() > 0) ? cks_q[0] : 16'hx, exp_sum);
    end
    checks++; if (p_errs != 0) begin errors++; $display("FAIL underrun_stream: got %0d errors expected 0", p_errs); end
    checks++; if (frame_count !== 32'd1) begin errors++; $display("FAIL underrun_frame_count: got %0d expected 1", frame_count); end
  endtask

  task automatic test_cksum_wrap();
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < FW; i++) src_q.push_back(16'hFFFF);
    drive(40, 100, -1, 0, -1);
    parse(8'd0);
    checks++;
    if (cks_q.size() != 1 || cks_q[0] !== 16'hFFFA) begin
      errors++; $display("FAIL cksum_wrap: got %0d words first %h expected fffa", cks_q.size(), (cks_q.size() > 0) ? cks_q[0] : 16'hx);
    end
    checks++; if (p_errs != 0) begin errors++; $display("FAIL cksum_wrap_stream: got %0d errors expected 0", p_errs); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 256 * FW; i++) src_q.push_back(16'($urandom));
    drive(256 * (FW + 3 + GAP) + 60, 100, -1, 0, -1);
    parse(8'd0);
    checks++; if (src_q.size() != 0) begin errors++; $display("FAIL b2b_drained: got %0d left expected 0", src_q.size()); end
    checks++; if (p_frames != 256) begin errors++; $display("FAIL b2b_frames_seen: got %0d expected 256", p_frames); end
    checks++; if (frame_count !== 32'd256) begin errors++; $display("FAIL b2b_frame_count: got %0d expected 256", frame_count); end
    checks++; if (seq !== 8'h00) begin errors++; $display("FAIL b2b_seq_wrap: got %h expected 00", seq); end
    checks++; if (p_min_gap != GAP || p_max_gap != GAP) begin errors++; $display("FAIL b2b_gap: got min %0d max %0d expected %0d", p_min_gap, p_max_gap, GAP); end
    checks++; if (p_errs != 0 || p_leftover != 0) begin errors++; $display("FAIL b2b_stream: got %0d errors %0d leftover expected 0", p_errs, p_leftover); end
    checks++; if (underrun_count !== 16'd0) begin errors++; $display("FAIL b2b_underrun: got %0d expected 0", underrun_count); end
  endtask

  task automatic test_random();
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 6 * FW; i++) src_q.push_back(16'($urandom));
    drive(400, 60, -1, 0, -1);
    parse(8'd0);
    checks++; if (p_frames != 6 || frame_count !== 32'd6) begin errors++; $display("FAIL random_frames: got %0d/%0d expected 6", p_frames, frame_count); end
    checks++; if (p_errs != 0 || p_leftover != 0 || p_mode_end != 0) begin errors++; $display("FAIL random_stream: got %0d errors %0d leftover mode %0d expected 0", p_errs, p_leftover, p_mode_end); end
    checks++; if (underrun_count !== 16'(p_underruns)) begin errors++; $display("FAIL random_underrun: got %0d expected %0d", underrun_count, p_underruns); end
    checks++; if (p_min_gap < GAP || p_first_gap < GAP) begin errors++; $display("FAIL random_gap: got %0d/%0d expected >= %0d", p_first_gap, p_min_gap, GAP); end
    checks++; if (seq !== 8'd6) begin errors++; $display("FAIL random_seq: got %0d expected 6", seq); end
  endtask

  task automatic test_disable();
    do_reset();
    enable = 1'b0;
    for (int i = 0; i < 2 * FW; i++) src_q.push_back(16'($urandom));
    drive(60, 100, -1, 0, -1);
    parse(8'd0);
    checks++; if (acc_q.size() != 0 || p_errs != 0 || p_frames != 0 || p_mode_end != 0) begin
      errors++; $display("FAIL disable_idle: got %0d accepted %0d errors %0d frames expected all 0", acc_q.size(), p_errs, p_frames);
    end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL disable_in_ready: got %b expected 0", in_ready); end
    tx_q.delete();
    acc_q.delete();
    enable = 1'b1;
    drive(80, 100, -1, 0, 2);
    parse(8'd0);
    checks++; if (p_frames != 1 || frame_count !== 32'd1) begin errors++; $display("FAIL disable_mid_frame: got %0d/%0d frames expected 1", p_frames, frame_count); end
    checks++; if (src_q.size() != FW) begin errors++; $display("FAIL disable_stays_idle: got %0d left expected %0d", src_q.size(), FW); end
    checks++; if (p_errs != 0 || p_mode_end != 0) begin errors++; $display("FAIL disable_stream: got %0d errors expected 0", p_errs); end
  endtask

  task automatic test_reset_mid();
    int acc = 0;
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < FW; i++) src_q.push_back(16'($urandom));
    for (int c = 0; c < 40 && acc < 3; c++) begin
      in_valid = 1'b1; in_data = src_q[0];
      @(negedge clk);
      if (in_ready) begin void'(src_q.pop_front()); acc++; end
      @(posedge clk); #1;
    end
    checks++; if (acc != 3) begin errors++; $display("FAIL reset_mid_reach: got %0d words expected 3", acc); end
    reset_n = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (tx_d !== 16'h50BC || tx_k !== 2'b01) begin errors++; $display("FAIL reset_mid_tx: got %h/%b expected 50bc/01", tx_d, tx_k); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_mid_in_ready: got %b expected 0", in_ready); end
    checks++; if (frame_count !== 32'd0) begin errors++; $display("FAIL reset_mid_frame_count: got %0d expected 0", frame_count); end
    @(posedge clk); #1;
    tx_q.delete();
    acc_q.delete();
    src_q.delete();
    reset_n = 1'b1;
    for (int i = 0; i < FW; i++) src_q.push_back(16'($urandom));
    drive(40, 100, -1, 0, -1);
    parse(8'd0);
    checks++; if (p_frames != 1 || p_errs != 0) begin errors++; $display("FAIL reset_mid_next_frame: got %0d frames %0d errors expected 1/0", p_frames, p_errs); end
    checks++; if (p_first_gap < GAP) begin errors++; $display("FAIL reset_mid_gap: got %0d expected >= %0d", p_first_gap, GAP); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_underrun();
    test_cksum_wrap();
    test_back_to_back();
    test_random();
    test_disable();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
